// File: rtl/brush_motor_pkg.sv
// Shared definitions for the brush motor ramp sequencer: FSM states,
// register maps of this block and of the driven brush_motor_driver, default ID.
// Optional feature macro: BRUSH_RAMP_DEADTIME_EN (DEADTIME register + DEAD state).
package brush_motor_pkg;

    localparam int DATA_W = 32;

    localparam logic [31:0] DEFAULT_ID = 32'hEA680103;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_W_DIR,
        ST_W_ON,
        ST_RUN,
        ST_W_W,
        ST_W_OFF,
        ST_DEAD
    } state_t;

    // Slave register word addresses
    localparam logic [2:0] REG_ID       = 3'd0;
    localparam logic [2:0] REG_TARGET   = 3'd1;
    localparam logic [2:0] REG_STEP     = 3'd2;
    localparam logic [2:0] REG_INTERVAL = 3'd3;
    localparam logic [2:0] REG_CTRL     = 3'd4;
    localparam logic [2:0] REG_DEADTIME = 3'd5;
    localparam logic [2:0] REG_STATUS   = 3'd6;
    localparam logic [2:0] REG_CUR      = 3'd7;

    // Driver register word addresses
    localparam logic [2:0] DRV_WIDTH = 3'd2;
    localparam logic [2:0] DRV_ONOFF = 3'd3;
    localparam logic [2:0] DRV_DIR   = 3'd4;

    // Merge a 32-bit write into an existing value lane by lane
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/brush_ramp_step.sv
// Combinational saturating step: moves cur toward eff_target by at most
// step, landing exactly on the target instead of overshooting or wrapping.
module brush_ramp_step
    import brush_motor_pkg::*;
(
    input  logic [DATA_W-1:0] cur,
    input  logic [DATA_W-1:0] eff_target,
    input  logic [DATA_W-1:0] step,
    output logic [DATA_W-1:0] nxt
);

    logic [DATA_W-1:0] diff;

    // Distance to target decides between a full step and a final snap
    always_comb begin
        diff = '0;
        nxt  = cur;
        if (cur < eff_target) begin
            diff = eff_target - cur;
            nxt  = (diff <= step) ? eff_target : cur + step;
        end else if (cur > eff_target) begin
            diff = cur - eff_target;
            nxt  = (diff <= step) ? eff_target : cur - step;
        end
    end

endmodule

// File: rtl/brush_motor_ramp_ctrl.sv
// Avalon-MM ramp sequencer in front of one brush_motor_driver: ramps the
// driver PWM width toward TARGET and runs the safe reversal sequence.
// Optional feature macro: BRUSH_RAMP_DEADTIME_EN enables the DEADTIME
// register and the DEAD state between switch-off and direction flip.
module brush_motor_ramp_ctrl
    import brush_motor_pkg::*;
#(
    parameter logic [31:0] ID_VALUE = DEFAULT_ID
)
(
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic [31:0] avs_ctrl_writedata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic        avs_ctrl_read,
    output logic [31:0] avs_ctrl_readdata,
    output logic        avs_ctrl_waitrequest,
    output logic [2:0]  avm_drv_address,
    output logic        avm_drv_write,
    output logic [31:0] avm_drv_writedata,
    input  logic        avm_drv_waitrequest
);

    logic [DATA_W-1:0] target_r, step_r, interval_r;
    logic              enable_r, dir_req_r;
`ifdef BRUSH_RAMP_DEADTIME_EN
    logic [DATA_W-1:0] deadtime_r;
`endif

    state_t            state;
    logic [DATA_W-1:0] cur, cnt, nxt, eff_target, ivl_m1, rd_data;
    logic              cur_dir, tick, off_req, busy, at_target;

    assign avs_ctrl_waitrequest = 1'b0;

    assign eff_target = (enable_r && (dir_req_r == cur_dir)) ? target_r : '0;
    assign ivl_m1     = (interval_r == '0) ? '0 : interval_r - 32'd1;
    assign tick       = (cnt >= ivl_m1);
    assign off_req    = (cur == '0) && (eff_target == '0) && (!enable_r || (dir_req_r != cur_dir));
    assign busy       = (state != ST_IDLE);
    // at_target is reported only while sequencing, so an idle block reads STATUS = 0
    assign at_target  = busy && (cur == eff_target);

    brush_ramp_step u_step (
        .cur        (cur),
        .eff_target (eff_target),
        .step       (step_r),
        .nxt        (nxt)
    );

    // Software-visible configuration registers
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            target_r   <= '0;
            step_r     <= '0;
            interval_r <= '0;
            enable_r   <= 1'b0;
            dir_req_r  <= 1'b0;
`ifdef BRUSH_RAMP_DEADTIME_EN
            deadtime_r <= '0;
`endif
        end else if (avs_ctrl_write) begin
            case (avs_ctrl_address)
                REG_TARGET:   target_r   <= be_merge(target_r, avs_ctrl_writedata, avs_ctrl_byteenable);
                REG_STEP:     step_r     <= be_merge(step_r, avs_ctrl_writedata, avs_ctrl_byteenable);
                REG_INTERVAL: interval_r <= be_merge(interval_r, avs_ctrl_writedata, avs_ctrl_byteenable);
                REG_CTRL: begin
                    if (avs_ctrl_byteenable[0]) begin
                        enable_r  <= avs_ctrl_writedata[0];
                        dir_req_r <= avs_ctrl_writedata[1];
                    end
                end
`ifdef BRUSH_RAMP_DEADTIME_EN
                REG_DEADTIME: deadtime_r <= be_merge(deadtime_r, avs_ctrl_writedata, avs_ctrl_byteenable);
`endif
                default: ;
            endcase
        end
    end

    // Read mux for the register map
    always_comb begin
        rd_data = '0;
        case (avs_ctrl_address)
            REG_ID:       rd_data = ID_VALUE;
            REG_TARGET:   rd_data = target_r;
            REG_STEP:     rd_data = step_r;
            REG_INTERVAL: rd_data = interval_r;
            REG_CTRL:     rd_data = {30'b0, dir_req_r, enable_r};
`ifdef BRUSH_RAMP_DEADTIME_EN
            REG_DEADTIME: rd_data = deadtime_r;
`endif
            REG_STATUS:   rd_data = {29'b0, cur_dir, at_target, busy};
            REG_CUR:      rd_data = cur;
            default:      rd_data = '0;
        endcase
    end

    // Registered read data; a simultaneous write suppresses the read
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            avs_ctrl_readdata <= '0;
        end else if (avs_ctrl_read && !avs_ctrl_write) begin
            avs_ctrl_readdata <= rd_data;
        end
    end

    // Sequencer FSM with registered master outputs; in each write state a low
    // write means "not yet issued", which also yields the idle cycle between writes
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            state             <= ST_IDLE;
            cur               <= '0;
            cur_dir           <= 1'b0;
            cnt               <= '0;
            avm_drv_write     <= 1'b0;
            avm_drv_address   <= '0;
            avm_drv_writedata <= '0;
        end else begin
            cnt <= '0;
            case (state)
                ST_IDLE: begin
                    if (enable_r) begin
                        cur_dir           <= dir_req_r;
                        avm_drv_write     <= 1'b1;
                        avm_drv_address   <= DRV_DIR;
                        avm_drv_writedata <= {31'b0, dir_req_r};
                        state             <= ST_W_DIR;
                    end
                end
                ST_W_DIR: begin
                    if (!avm_drv_write) begin
                        avm_drv_write     <= 1'b1;
                        avm_drv_address   <= DRV_DIR;
                        avm_drv_writedata <= {31'b0, cur_dir};
                    end else if (!avm_drv_waitrequest) begin
                        avm_drv_write <= 1'b0;
                        state         <= ST_W_ON;
                    end
                end
                ST_W_ON: begin
                    if (!avm_drv_write) begin
                        avm_drv_write     <= 1'b1;
                        avm_drv_address   <= DRV_ONOFF;
                        avm_drv_writedata <= 32'd1;
                    end else if (!avm_drv_waitrequest) begin
                        avm_drv_write <= 1'b0;
                        state         <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    cnt <= tick ? '0 : cnt + 32'd1;
                    if (tick && (nxt != cur)) begin
                        cur   <= nxt;
                        state <= ST_W_W;
                    end else if (off_req) begin
                        state <= ST_W_OFF;
                    end
                end
                ST_W_W: begin
                    if (!avm_drv_write) begin
                        avm_drv_write     <= 1'b1;
                        avm_drv_address   <= DRV_WIDTH;
                        avm_drv_writedata <= cur;
                    end else if (!avm_drv_waitrequest) begin
                        avm_drv_write <= 1'b0;
                        state         <= ST_RUN;
                    end
                end
                ST_W_OFF: begin
                    if (!avm_drv_write) begin
                        avm_drv_write     <= 1'b1;
                        avm_drv_address   <= DRV_ONOFF;
                        avm_drv_writedata <= 32'd0;
                    end else if (!avm_drv_waitrequest) begin
                        avm_drv_write <= 1'b0;
`ifdef BRUSH_RAMP_DEADTIME_EN
                        state <= enable_r ? ST_DEAD : ST_IDLE;
`else
                        if (enable_r) begin
                            cur_dir <= dir_req_r;
                            state   <= ST_W_DIR;
                        end else begin
                            state <= ST_IDLE;
                        end
`endif
                    end
                end
`ifdef BRUSH_RAMP_DEADTIME_EN
                ST_DEAD: begin
                    if (cnt >= deadtime_r) begin
                        cur_dir <= dir_req_r;
                        state   <= ST_W_DIR;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_brush_motor_ramp_ctrl.sv
// Directed bench for brush_motor_ramp_ctrl: expected driver write sequences
// come from a transaction-level ramp model plus hand-computed literals.
module tb_brush_motor_ramp_ctrl;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic [2:0]  s_addr = '0;
    logic        s_wr   = 1'b0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_be   = 4'hF;
    logic        s_rd   = 1'b0;
    logic [31:0] s_rdata;
    logic        s_wait;
    logic [2:0]  m_addr;
    logic        m_wr;
    logic [31:0] m_wdata;
    logic        m_wait = 1'b0;

`ifdef BRUSH_RAMP_DEADTIME_EN
    localparam logic [31:0] DT_EXP  = 32'd5;
    localparam int          MIN_GAP = 5;
`else
    localparam logic [31:0] DT_EXP  = 32'd0;
    localparam int          MIN_GAP = 1;
`endif

    brush_motor_ramp_ctrl dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset_n     (rst_n),
        .avs_ctrl_address     (s_addr),
        .avs_ctrl_write       (s_wr),
        .avs_ctrl_writedata   (s_wdata),
        .avs_ctrl_byteenable  (s_be),
        .avs_ctrl_read        (s_rd),
        .avs_ctrl_readdata    (s_rdata),
        .avs_ctrl_waitrequest (s_wait),
        .avm_drv_address      (m_addr),
        .avm_drv_write        (m_wr),
        .avm_drv_writedata    (m_wdata),
        .avm_drv_waitrequest  (m_wait)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_comp = 0;

    typedef struct { logic [2:0] a; logic [31:0] d; } wr_t;
    wr_t exp_q[$];
    int  comp_cyc[$];
    int  rise_cyc[$];

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endfunction

    function automatic void exp_push(input logic [2:0] a, input logic [31:0] d);
        wr_t w;
        w.a = a;
        w.d = d;
        exp_q.push_back(w);
    endfunction

    // Model: every width the driver must see while ramping from -> to
    function automatic void push_ramp(input int unsigned from, input int unsigned to,
                                      input int unsigned step);
        int unsigned c = from;
        while (c != to) begin
            if (to > c) c = (to - c <= step) ? to : c + step;
            else        c = (c - to <= step) ? to : c - step;
            exp_push(3'd2, c);
        end
    endfunction

    // Driver-side monitor: protocol and expected-write scoreboard
    logic        prev_wr = 1'b0, prev_wait = 1'b0, prev_done = 1'b0;
    logic [2:0]  prev_a  = '0;
    logic [31:0] prev_d  = '0;
    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (!rst_n) begin
            prev_wr   = 1'b0;
            prev_done = 1'b0;
        end else begin
            if (prev_wr && prev_wait) begin
                chk("hold_write", {31'b0, m_wr}, 32'd1);
                chk("hold_addr", {29'b0, m_addr}, {29'b0, prev_a});
                chk("hold_data", m_wdata, prev_d);
            end
            if (prev_done) chk("idle_after_write", {31'b0, m_wr}, 32'd0);
            if (m_wr && !prev_wr) rise_cyc.push_back(cyc);
            if (m_wr && !m_wait) begin
                n_comp++;
                comp_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write_addr", {29'b0, m_addr}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("drv_addr", {29'b0, m_addr}, {29'b0, e.a});
                    chk("drv_data", m_wdata, e.d);
                end
            end
            prev_wr   = m_wr;
            prev_wait = m_wait;
            prev_a    = m_addr;
            prev_d    = m_wdata;
            prev_done = m_wr && !m_wait;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic avs_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
        s_addr = a; s_wdata = d; s_be = be; s_wr = 1'b1;
        @(posedge clk); #1;
        s_wr = 1'b0; s_be = 4'hF;
    endtask

    task automatic avs_rd(input logic [2:0] a, output logic [31:0] d);
        s_addr = a; s_rd = 1'b1;
        @(posedge clk); #1;
        s_rd = 1'b0;
        d = s_rdata;
    endtask

    task automatic wait_drain(input string nm, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        chk(nm, exp_q.size(), 32'd0);
    endtask

    task automatic wait_wr_high(input string nm);
        int n = 0;
        while (!m_wr && n < 100) begin
            tick(1);
            n++;
        end
        chk(nm, {31'b0, m_wr}, 32'd1);
    endtask

    initial begin
        logic [31:0] rd;
        int k0, n0, k, n, gap;

        // Reset state
        tick(3);
        chk("rst_readdata", s_rdata, 32'd0);
        chk("rst_m_write", {31'b0, m_wr}, 32'd0);
        chk("rst_m_addr", {29'b0, m_addr}, 32'd0);
        chk("rst_m_data", m_wdata, 32'd0);
        chk("s_waitrequest", {31'b0, s_wait}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        avs_rd(3'd6, rd); chk("status_reset", rd, 32'd0);
        avs_rd(3'd0, rd); chk("id", rd, 32'hEA680103);

        // Write and read in the same cycle: write wins, readdata holds ID
        s_addr = 3'd1; s_wdata = 32'h33; s_be = 4'hF; s_wr = 1'b1; s_rd = 1'b1;
        tick(1);
        s_wr = 1'b0; s_rd = 1'b0;
        chk("rd_wr_collision", s_rdata, 32'hEA680103);
        avs_rd(3'd1, rd); chk("target_after_collision", rd, 32'h33);

        // Byte lanes
        avs_wr(3'd1, 32'h11223344, 4'hF);
        avs_wr(3'd1, 32'hAABBCCDD, 4'b0100);
        avs_rd(3'd1, rd); chk("target_be", rd, 32'h11BB3344);
        avs_wr(3'd4, 32'h3, 4'b0010);
        avs_rd(3'd4, rd); chk("ctrl_be_ignored", rd, 32'd0);
        avs_wr(3'd5, 32'd5, 4'hF);
        avs_rd(3'd5, rd); chk("deadtime_reg", rd, DT_EXP);
        tick(10);
        chk("no_write_idle", n_comp, 32'd0);

        // Ramp up 0 -> 10 by 4
        avs_wr(3'd1, 32'd10, 4'hF);
        avs_wr(3'd2, 32'd4, 4'hF);
        avs_wr(3'd3, 32'd2, 4'hF);
        exp_push(3'd4, 32'd0); exp_push(3'd3, 32'd1);
        exp_push(3'd2, 32'd4); exp_push(3'd2, 32'd8); exp_push(3'd2, 32'd10);
        avs_wr(3'd4, 32'd1, 4'hF);
        chk("enable_latency_c1", {31'b0, m_wr}, 32'd0);
        tick(1);
        chk("enable_latency_c2", {28'b0, m_wr, m_addr}, 32'hC);
        wait_drain("ramp_up_drain", 200);
        k = comp_cyc.size();
        chk("step_period", comp_cyc[k-1] - comp_cyc[k-2], 32'd4);
        tick(2);
        avs_rd(3'd6, rd); chk("status_at_target", rd, 32'd3);
        avs_rd(3'd7, rd); chk("cur_10", rd, 32'd10);

        // Reversal at width 10
        k0 = comp_cyc.size();
        push_ramp(10, 0, 4);
        exp_push(3'd3, 32'd0); exp_push(3'd4, 32'd1); exp_push(3'd3, 32'd1);
        push_ramp(0, 10, 4);
        avs_wr(3'd4, 32'd3, 4'hF);
        wait_drain("reversal_drain", 400);
        if (rise_cyc.size() > k0 + 4 && comp_cyc.size() > k0 + 3) begin
            gap = rise_cyc[k0+4] - comp_cyc[k0+3] - 1;
            chk("dead_gap", {31'b0, (gap >= MIN_GAP)}, 32'd1);
        end else begin
            chk("dead_gap_records", rise_cyc.size(), k0 + 5);
        end
        tick(2);
        avs_rd(3'd6, rd); chk("status_reversed", rd, 32'd7);

        // Stalled width write
        m_wait = 1'b1;
        n0 = n_comp;
        exp_push(3'd2, 32'd14);
        avs_wr(3'd1, 32'd14, 4'hF);
        wait_wr_high("stall_write_seen");
        chk("stall_addr", {29'b0, m_addr}, 32'd2);
        chk("stall_data", m_wdata, 32'd14);
        tick(7);
        m_wait = 1'b0;
        tick(3);
        chk("stall_one_write", n_comp - n0, 32'd1);
        wait_drain("stall_drain", 20);

        // Back to 10, then disable with STEP=3
        exp_push(3'd2, 32'd10);
        avs_wr(3'd1, 32'd10, 4'hF);
        wait_drain("back_to_10", 100);
        avs_wr(3'd2, 32'd3, 4'hF);
        exp_push(3'd2, 32'd7); exp_push(3'd2, 32'd4); exp_push(3'd2, 32'd1);
        exp_push(3'd2, 32'd0); exp_push(3'd3, 32'd0);
        avs_wr(3'd4, 32'd0, 4'hF);
        wait_drain("disable_drain", 200);
        tick(3);
        avs_rd(3'd6, rd); chk("status_disabled", rd, 32'd4);
        avs_rd(3'd7, rd); chk("cur_disabled", rd, 32'd0);

        // Reset in the middle of a stalled ramp write
        avs_wr(3'd1, 32'd100, 4'hF);
        avs_wr(3'd2, 32'd1, 4'hF);
        avs_wr(3'd3, 32'd3, 4'hF);
        exp_push(3'd4, 32'd0); exp_push(3'd3, 32'd1);
        push_ramp(0, 100, 1);
        n0 = n_comp;
        avs_wr(3'd4, 32'd1, 4'hF);
        n = 0;
        while (n_comp < n0 + 5 && n < 300) begin
            tick(1);
            n++;
        end
        chk("ramp_progress", {31'b0, (n_comp >= n0 + 5)}, 32'd1);
        m_wait = 1'b1;
        wait_wr_high("pre_reset_write");
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("async_reset_write", {31'b0, m_wr}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        m_wait = 1'b0;
        exp_q.delete();
        tick(2);
        avs_rd(3'd7, rd); chk("cur_after_reset", rd, 32'd0);
        avs_rd(3'd6, rd); chk("status_after_reset", rd, 32'd0);
        n0 = n_comp;
        tick(10);
        chk("no_write_after_reset", n_comp - n0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/brush_motor_ramp_ctrl.md
# brush_motor_ramp_ctrl

Avalon-MM sequencer that drives a `brush_motor_driver` instance through that driver's own control slave. Software sets a target PWM width, ramp step, step interval and direction. The block then ramps the driver's PWM width toward the target and runs the safe reversal sequence: ramp to zero, switch off, dead time, flip direction, switch on, ramp up. It sits on the Qsys fabric between the CPU and one motor driver.

## Interface
Parameters:
- `ID_VALUE`, default 32'hEA680103: constant returned at register 0.

Ports:
- `csi_MCLK_clk`, input, 1: the single clock for both the slave and the master.
- `rsi_MRST_reset_n`, input, 1: asynchronous, active-low reset.
- `avs_ctrl_address`, input, 3: word address into this block's register map.
- `avs_ctrl_write`, input, 1: register write strobe.
- `avs_ctrl_writedata`, input, 32: register write data.
- `avs_ctrl_byteenable`, input, 4: byte lanes for writes to 32-bit registers.
- `avs_ctrl_read`, input, 1: register read strobe.
- `avs_ctrl_readdata`, output, 32: registered read data.
- `avs_ctrl_waitrequest`, output, 1: tied to 0.
- `avm_drv_address`, output, 3: word address of the driver register being written.
- `avm_drv_write`, output, 1: write request to the driver.
- `avm_drv_writedata`, output, 32: data for the driver register.
- `avm_drv_waitrequest`, input, 1: driver stall.

## Operation
Register map (word addresses):
- 0 ID: read-only, returns `ID_VALUE`.
- 1 TARGET: 32-bit target PWM width.
- 2 STEP: 32-bit width change per tick.
- 3 INTERVAL: cycles between ticks; a value of 0 behaves as 1.
- 4 CTRL: bit0 `enable`, bit1 `dir_req`.
- 5 DEADTIME: cycles of dead time.
- 6 STATUS, read-only: bit0 `busy` (state ≠ IDLE), bit1 `at_target` (`cur == eff_target`), bit2 `cur_dir`.
- 7 CUR: read-only, current width.
- Writes to 1, 2, 3 and 5 honour byteenable. CTRL writes honour byteenable[0] only.

Driver writes issued by the master:
- Address 2: width, data = `cur`.
- Address 3: on_off, data = {31'b0, bit}.
- Address 4: forward_back, data = {31'b0, `cur_dir`}.

Effective target: `eff_target` = TARGET when `enable` = 1 and `dir_req` = `cur_dir`; otherwise 0.

State machine:
- IDLE (`cur` = 0): on `enable` = 1, latch `cur_dir` ← `dir_req`, then go to W_DIR.
- W_DIR: write address 4, then go to W_ON.
- W_ON: write address 3 with 1, then go to RUN.
- RUN:
  - The interval counter counts INTERVAL cycles, then ticks.
  - On a tick, compute `nxt` by saturating step (below). If `nxt` ≠ `cur`, set `cur` ← `nxt` and go to W_W.
  - If `cur` == 0 and `eff_target` == 0 with (`enable` = 0 or `dir_req` ≠ `cur_dir`), go to W_OFF.
- W_W: write address 2 with `cur`, return to RUN, and reload the interval counter.
- W_OFF: write address 3 with 0. Then go to IDLE if `enable` = 0, otherwise to DEAD.
- DEAD: count DEADTIME cycles, latch `cur_dir` ← `dir_req`, then go to W_DIR.

Saturating step:
- If `cur` < `eff_target`: `nxt` = (`eff_target` − `cur` ≤ STEP) ? `eff_target` : `cur` + STEP.
- The falling direction is symmetric.
- The result never overshoots and never wraps.
- STEP = 0 freezes `cur`.

Boundary conditions:
- CTRL, TARGET or STEP changes take effect at the next RUN decision. They never abort a pending master write.
- `dir_req` toggling back before `cur` reaches 0 resumes the ramp toward TARGET with no W_OFF.
- A slave write and a slave read in the same cycle: the write wins, and `readdata` holds its previous value.

## Timing
- Reset values: all registers, `cur`, `cur_dir` and counters are 0. State is IDLE.
- Reset values of outputs: `avm_drv_write` = 0, `avm_drv_address` = 0, `avm_drv_writedata` = 0, `avs_ctrl_readdata` = 0.
- Reset mid-write drops `avm_drv_write` asynchronously. Software must re-enable afterwards.
- Slave read latency: 1 cycle.
- Master handshake:
  - Address, data and write are registered and held stable while `avm_drv_waitrequest` = 1.
  - A write completes in the cycle where write = 1 and waitrequest = 0. `avm_drv_write` deasserts the next cycle.
  - The master never issues back-to-back writes without one idle cycle.
- `enable` written in IDLE → `avm_drv_write` (address 4) asserts 2 cycles after the slave write cycle.
- Step period = INTERVAL + write completion time + 1 cycle.

## Configuration
Macro `BRUSH_RAMP_DEADTIME_EN`:
- Defined: DEADTIME register and DEAD state are present as described.
- Undefined: W_OFF goes directly to W_DIR (`cur_dir` latched there). Register 5 reads 0 and ignores writes.

## Structure
- Package `brush_motor_pkg` holds:
  - the state enum;
  - this block's register address constants (0–7);
  - the driver register address constants (2, 3, 4);
  - the default ID.
- Sub-module `brush_ramp_step` computes the combinational saturating `nxt` from (`cur`, `eff_target`, STEP).

## Test plan
- Reset, then read register 0 → 32'hEA680103. Read STATUS → 0. No master write occurs.
- TARGET=10, STEP=4, INTERVAL=2, CTRL=1, waitrequest=0 → driver writes addr4=0, addr3=1, then addr2 = 4, 8, 10. STATUS.at_target = 1.
- At width 10, set CTRL=3 with DEADTIME=5 → addr2 = 6, 2, 0; then addr3=0; ≥5 idle cycles; addr4=1; addr3=1; then ramp to 10.
- `avm_drv_waitrequest` held high for 7 cycles during an addr2 write → address/data stable throughout, exactly one completed write.
- CTRL=0 at width 10, STEP=3 → addr2 = 7, 4, 1, 0; addr3=0; STATUS.busy = 0.
- Drive `rsi_MRST_reset_n` low mid-ramp → `avm_drv_write` = 0 immediately, CUR reads 0 after release.
